// File: rtl/vga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_pkg : default 640x480@60 timing, coordinate/colour types, bar palette
// Rev 1.0
// ----------------------------------------------------------------------------
package vga_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [7:0]         rgb_t;   // RRRGGGBB

  localparam rgb_t BAR_WHITE   = 8'hFF;
  localparam rgb_t BAR_YELLOW  = 8'hFC;
  localparam rgb_t BAR_CYAN    = 8'h1F;
  localparam rgb_t BAR_GREEN   = 8'h1C;
  localparam rgb_t BAR_MAGENTA = 8'hE3;
  localparam rgb_t BAR_RED     = 8'hE0;
  localparam rgb_t BAR_BLUE    = 8'h03;
  localparam rgb_t BAR_BLACK   = 8'h00;

  function automatic rgb_t bar_colour(input coord_t idx);
    case (idx)
      10'd0:   bar_colour = BAR_WHITE;
      10'd1:   bar_colour = BAR_YELLOW;
      10'd2:   bar_colour = BAR_CYAN;
      10'd3:   bar_colour = BAR_GREEN;
      10'd4:   bar_colour = BAR_MAGENTA;
      10'd5:   bar_colour = BAR_RED;
      10'd6:   bar_colour = BAR_BLUE;
      default: bar_colour = BAR_BLACK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_axis_counter : enabled 0..TOTAL-1 wrapping counter with look-ahead value
// Rev 1.0
// ----------------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL = DEF_H_TOTAL
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               en_i,
  output logic [COORD_W-1:0] count_o,
  output logic [COORD_W-1:0] next_count_o,
  output logic               wrap_o
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  coord_t count_q;
  coord_t count_d;
  logic   at_last;

  assign at_last = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = at_last ? '0 : count_q + coord_t'(1);
    end
  end

  // Reset parks on the last position so the first enable lands on zero.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      count_q <= LAST;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign next_count_o = count_d;
  assign wrap_o       = en_i & at_last;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_timing_gen : 640x480@60 raster timing on a pixel-tick enable;
// VGA_TEST_PATTERN_EN adds an eight-bar colour test pattern on rgb.  Rev 1.0
// ----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic [7:0]         rgb
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);

  if (H_TOTAL > 1024) begin : g_h_total_check
    $error("vga_timing_gen: H_TOTAL %0d exceeds 1024", H_TOTAL);
  end
  if (V_TOTAL > 1024) begin : g_v_total_check
    $error("vga_timing_gen: V_TOTAL %0d exceeds 1024", V_TOTAL);
  end

  coord_t h_count, h_next, v_count, v_next;
  logic   h_wrap, v_wrap, v_en;

  assign v_en = pix_en & h_wrap;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_counter (
    .clk          (clk),
    .rst_i        (reset),
    .en_i         (pix_en),
    .count_o      (h_count),
    .next_count_o (h_next),
    .wrap_o       (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_counter (
    .clk          (clk),
    .rst_i        (reset),
    .en_i         (v_en),
    .count_o      (v_count),
    .next_count_o (v_next),
    .wrap_o       (v_wrap)
  );

  logic hsync_d, vsync_d, video_on_d;
  logic hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

  // Decode from the look-ahead counts so registered outputs line up with x/y.
  always_comb begin
    hsync_d    = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d    = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    video_on_d = (h_next < H_VIS) && (v_next < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
      if (pix_en) begin
        hsync_q    <= hsync_d;
        vsync_q    <= vsync_d;
        video_on_q <= video_on_d;
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam coord_t BAR_W = coord_t'(H_VISIBLE / 8);

  rgb_t rgb_q;
  rgb_t rgb_d;

  assign rgb_d = video_on_d ? bar_colour(h_next / BAR_W) : BAR_BLACK;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= BAR_BLACK;
    end else if (pix_en) begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;
`else
  assign rgb = BAR_BLACK;
`endif

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign x           = h_count;
  assign y           = v_count;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire
